// File: rtl/instruction_queue_if.sv
// Fetch/decoder/flush signals of the instruction queue, bundled into one interface.
// The slave modport is the queue side; the master modport is the fetch/decoder/ROB side.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

interface instruction_queue_if;
  logic                     if_instqueue_en_in;
  logic [`IDWidth-1:0]      if_instqueue_inst_in;
  logic [`AddressWidth-1:0] if_instqueue_pc_in;
  logic                     instqueue_if_full_out;
  logic                     instqueue_decoder_en_out;
  logic [`IDWidth-1:0]      instqueue_decoder_inst_out;
  logic [`AddressWidth-1:0] instqueue_decoder_pc_out;
  logic                     decoder_instqueue_rst_in;
  logic                     dispatcher_instqueue_stall_in;
  logic                     rob_instqueue_rst_in;

  modport slave (
    input  if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    input  decoder_instqueue_rst_in, dispatcher_instqueue_stall_in, rob_instqueue_rst_in,
    output instqueue_if_full_out, instqueue_decoder_en_out,
    output instqueue_decoder_inst_out, instqueue_decoder_pc_out
  );

  modport master (
    output if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    output decoder_instqueue_rst_in, dispatcher_instqueue_stall_in, rob_instqueue_rst_in,
    input  instqueue_if_full_out, instqueue_decoder_en_out,
    input  instqueue_decoder_inst_out, instqueue_decoder_pc_out
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular {inst, pc} FIFO between fetch and decode, flushed by JAL redirect or ROB mispredict.
// Optional INSTQUEUE_BYPASS_EN: an empty queue hands an incoming push straight to the decoder.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

module instruction_queue #(
  parameter int DEPTH_LOG  = 4,
  parameter int FULL_SLACK = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  instruction_queue_if.slave  iq
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT  = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] FULL_LEVEL = (DEPTH_LOG + 1)'(DEPTH - FULL_SLACK);

  logic [DEPTH_LOG-1:0]     head_q, head_d;
  logic [DEPTH_LOG-1:0]     tail_q, tail_d;
  logic [DEPTH_LOG:0]       count_q, count_d;
  logic [`IDWidth-1:0]      inst_mem_q [DEPTH];
  logic [`AddressWidth-1:0] pc_mem_q   [DEPTH];

  logic push;
  logic bypass;
  logic en;
  logic deq;
  logic mem_we;

  // en must never look at the decoder flush: the decoder derives that flush from our outputs.
  always_comb begin
    push   = rdy_in && iq.if_instqueue_en_in && (count_q != DEPTH_CNT);
    bypass = 1'b0;
`ifdef INSTQUEUE_BYPASS_EN
    bypass = (count_q == '0) && push && !iq.dispatcher_instqueue_stall_in
             && !iq.rob_instqueue_rst_in;
`endif
    en = rst_in && rdy_in && !iq.dispatcher_instqueue_stall_in && !iq.rob_instqueue_rst_in
         && ((count_q != '0) || bypass);
  end

  assign iq.instqueue_decoder_en_out   = en;
  assign iq.instqueue_decoder_inst_out = !en ? '0 :
                                         bypass ? iq.if_instqueue_inst_in : inst_mem_q[head_q];
  assign iq.instqueue_decoder_pc_out   = !en ? '0 :
                                         bypass ? iq.if_instqueue_pc_in : pc_mem_q[head_q];
  assign iq.instqueue_if_full_out      = (count_q >= FULL_LEVEL);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_we  = 1'b0;
    deq     = 1'b0;
    if (rdy_in) begin
      if (iq.rob_instqueue_rst_in || (iq.decoder_instqueue_rst_in && en)) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        // A bypassed entry is consumed on the wire and never occupies storage.
        mem_we = push && !bypass;
        deq    = en && !bypass;
        if (mem_we) tail_d = tail_q + DEPTH_LOG'(1);
        if (deq)    head_d = head_q + DEPTH_LOG'(1);
        if (mem_we && !deq)      count_d = count_q + (DEPTH_LOG + 1)'(1);
        else if (!mem_we && deq) count_d = count_q - (DEPTH_LOG + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      inst_mem_q[tail_q] <= iq.if_instqueue_inst_in;
      pc_mem_q[tail_q]   <= iq.if_instqueue_pc_in;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: pushes go into an expected queue, decoder outputs pop it.
// Honours INSTQUEUE_BYPASS_EN when the design is built with it.
`timescale 1ns/1ps

module tb_instruction_queue;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  instruction_queue_if iq_if ();

  instruction_queue dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .iq     (iq_if.slave)
  );

  always #5 clk_in = ~clk_in;

  entry_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle, check the decoder/full outputs against the scoreboard, then advance it.
  task automatic apply_stimulus(input logic push, input logic [31:0] pc, input logic stall,
                                input logic rob, input logic dec, input logic rdy);
    logic        exp_en;
    logic        byp;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    int          n;
    entry_t      e;
    n = sb.size();
    iq_if.if_instqueue_en_in            = push;
    iq_if.if_instqueue_pc_in            = pc;
    iq_if.if_instqueue_inst_in          = inst_of(pc);
    iq_if.dispatcher_instqueue_stall_in = stall;
    iq_if.rob_instqueue_rst_in          = rob;
    iq_if.decoder_instqueue_rst_in      = dec;
    rdy_in                              = rdy;
    #3;
    byp = 1'b0;
`ifdef INSTQUEUE_BYPASS_EN
    byp = rdy && push && (n == 0) && !stall && !rob;
`endif
    exp_en   = rdy && !stall && !rob && ((n != 0) || byp);
    exp_pc   = 32'h0;
    exp_inst = 32'h0;
    if (exp_en) begin
      if (byp) begin
        exp_pc   = pc;
        exp_inst = inst_of(pc);
      end else begin
        exp_pc   = sb[0].pc;
        exp_inst = sb[0].inst;
      end
    end
    check_output("en_out", 32'(iq_if.instqueue_decoder_en_out), 32'(exp_en));
    check_output("pc_out", iq_if.instqueue_decoder_pc_out, exp_pc);
    check_output("inst_out", iq_if.instqueue_decoder_inst_out, exp_inst);
    check_output("full_out", 32'(iq_if.instqueue_if_full_out), 32'(n >= 15));
    if (rdy) begin
      if (rob || (dec && exp_en)) begin
        sb.delete();
      end else begin
        if (exp_en && !byp) void'(sb.pop_front());
        if (push && !byp && n != 16) begin
          e.pc   = pc;
          e.inst = inst_of(pc);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    iq_if.if_instqueue_en_in            = 1'b0;
    iq_if.if_instqueue_pc_in            = 32'h0;
    iq_if.if_instqueue_inst_in          = 32'h0;
    iq_if.dispatcher_instqueue_stall_in = 1'b0;
    iq_if.rob_instqueue_rst_in          = 1'b0;
    iq_if.decoder_instqueue_rst_in      = 1'b0;
    #12;
    check_output("reset_en", 32'(iq_if.instqueue_decoder_en_out), 32'h0);
    check_output("reset_full", 32'(iq_if.instqueue_if_full_out), 32'h0);
    check_output("reset_pc", iq_if.instqueue_decoder_pc_out, 32'h0);
    check_output("reset_inst", iq_if.instqueue_decoder_inst_out, 32'h0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Reset mid-operation: three queued entries vanish as soon as rst_in falls.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
    iq_if.if_instqueue_en_in = 1'b0;
    iq_if.dispatcher_instqueue_stall_in = 1'b0;
    #1;
    rst_in = 1'b0;
    #1;
    check_output("midrst_en", 32'(iq_if.instqueue_decoder_en_out), 32'h0);
    check_output("midrst_pc", iq_if.instqueue_decoder_pc_out, 32'h0);
    check_output("midrst_full", 32'(iq_if.instqueue_if_full_out), 32'h0);
    sb.delete();
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Ordering and latency.
    apply_stimulus(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h1008, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Full and wrap: 17 pushes under stall, the last is dropped; then drain.
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(18);

    // JAL flush with a same-cycle push.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h20 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h2C, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // ROB flush beats push and pop.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Stall and rdy hold the head; a push while rdy is low is ignored.
    apply_stimulus(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h604, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

`ifdef INSTQUEUE_BYPASS_EN
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
`endif

    // Random mix of traffic, stalls, rdy drops and flushes.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 32'h8000 + 32'(4 * i),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between instruction fetch and the decoder. It buffers fetched {instruction, pc} pairs.
- Presents the head entry to the decoder, which decodes combinationally in the same cycle.
- Flushes on a JAL redirect from the decoder or on a mispredict reset from the reorder buffer.
- Back-pressures instruction fetch with an almost-full flag.

Parameters:
- DEPTH_LOG, 4: log2 of entry count; DEPTH = 2**DEPTH_LOG = 16.
- FULL_SLACK, 1: full flag asserts when count >= DEPTH - FULL_SLACK. Covers the one-cycle fetch reaction time.
- Data widths use `IDWidth (32) and `AddressWidth (32) from constant.vh.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, state holds and en out is low.
- if_instqueue_en_in  input  1  push request from fetch.
- if_instqueue_inst_in  input  `IDWidth  fetched instruction.
- if_instqueue_pc_in  input  `AddressWidth  pc of fetched instruction.
- instqueue_if_full_out  output  1  almost-full back-pressure to fetch.
- instqueue_decoder_en_out  output  1  head valid to decoder.
- instqueue_decoder_inst_out  output  `IDWidth  head instruction.
- instqueue_decoder_pc_out  output  `AddressWidth  head pc.
- decoder_instqueue_rst_in  input  1  JAL redirect flush from decoder; combinational from this cycle's head.
- dispatcher_instqueue_stall_in  input  1  downstream (RS/ROB/LSB) full; head must not be consumed.
- rob_instqueue_rst_in  input  1  mispredict flush from reorder buffer (registered source).

Behaviour:
- State:
  - head, tail: DEPTH_LOG bits each, wrap modulo DEPTH.
  - count: DEPTH_LOG+1 bits.
  - storage: DEPTH x (inst, pc), no reset needed.
- Reset (rst_in low, asynchronous): head=0, tail=0, count=0. All outputs 0 (full=0, en=0, inst=0, pc=0).
- Decoder outputs:
  - en_out = rdy_in && count!=0 && !dispatcher_instqueue_stall_in && !rob_instqueue_rst_in.
  - en_out must not depend on decoder_instqueue_rst_in; that would create a combinational loop through the decoder.
  - inst_out/pc_out = storage[head] when en_out high, else 0.
- pop = en_out. push = rdy_in && if_instqueue_en_in && count!=DEPTH.
  - A push arriving when count==DEPTH is dropped. Fetch must honour full_out, so this is an error condition.
- Each rising edge, first matching rule wins:
  1. rdy_in low: hold all state.
  2. rob_instqueue_rst_in high: head=tail=0, count=0. Any same-cycle push is discarded.
  3. decoder_instqueue_rst_in high: the head (the JAL) is consumed. All remaining entries and any same-cycle push are discarded; head=tail=0, count=0.
  4. Otherwise:
     - push writes storage[tail], tail+=1.
     - pop does head+=1.
     - count += push - pop. Simultaneous push and pop leave count unchanged, including at count==DEPTH-1 and count==1.
- Push/pop at count==0: the pushed entry becomes visible next cycle (one-cycle fill latency). The bypass feature below is the exception.
- Pointer wrap: tail=DEPTH-1 plus push gives tail=0; same rule for head.
- instqueue_if_full_out = (count >= DEPTH - FULL_SLACK), combinational from registered count. It is 0 in the cycle after any flush.
- decoder_instqueue_rst_in without en_out high is ignored; the decoder only raises it for a valid JAL.

Optional Feature:
- Macro: INSTQUEUE_BYPASS_EN.
- Defined:
  - When count==0, the incoming push is presented to the decoder in the same cycle. Condition: push && !stall && !rob_instqueue_rst_in.
  - In that case en_out=1 and inst_out/pc_out come directly from the if_instqueue_* inputs.
  - If consumed, the entry is not written and count stays 0.
  - A decoder flush in that cycle leaves the queue empty.
- Undefined: one-cycle fill latency as above; no input-to-output combinational path.

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst_in low between edges -> outputs 0 immediately, count 0; first push after release appears at pc 0x0 path ordering intact.
- Ordering and latency: push pc 0x1000,0x1004,0x1008 on consecutive cycles with stall=0 -> en_out high from cycle 2, decoder sees 0x1000,0x1004,0x1008 in order, en_out low afterwards.
- Full and wrap: stall=1, push 16 entries -> full_out rises when count=15. 16th push accepted, 17th dropped. Release stall -> 16 pops in order; tail/head wrap to 0; full_out falls when count<15.
- JAL flush: queue holds pc 0x20(JAL),0x24,0x28, fetch pushes 0x2C same cycle, decoder_instqueue_rst_in=1 -> next cycle count=0, en_out=0, 0x24/0x28/0x2C never presented.
- ROB flush priority: push, pop and rob_instqueue_rst_in together with count=5 -> next cycle count=0. en_out is low during the flush cycle.
- Stall and rdy: count=2, assert stall or drop rdy_in for 3 cycles -> en_out low, head unchanged; resume -> same head entry presented.
- (Bypass build) empty queue, push 0x40 with stall=0 -> en_out high same cycle with pc_out=0x40; next cycle count=0.
